// File: rtl/uram_event_write_sm_pkg.sv
// Shared constants, FSM state type and BRAM rotation helper for the URAM event writer.
package uram_event_pkg;

    localparam int NUM_SLOTS       = 4;
    localparam int SLOT_BITS       = 2;
    localparam int WORDS_PER_EVENT = 1536;
    localparam int NUM_BRAMS       = 3;
    localparam int LADDR_WORDS     = 4;
    // Highest uaddr reached by one event: 1536 / (3 brams * 4 laddr) - 1 = 127.
    localparam int UADDR_LAST      = WORDS_PER_EVENT / (NUM_BRAMS * LADDR_WORDS) - 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_e;

    function automatic logic [2:0] next_bram(input logic [2:0] b);
        return {b[1:0], b[2]};
    endfunction

endpackage

// File: rtl/uram_event_write_sm_if.sv
// Control/status bundle between the event writer and its environment.
interface uram_event_write_sm_if #(
    parameter int SLOT_BITS = uram_event_pkg::SLOT_BITS
);
    logic                 clk_ce_i;
    logic                 trig_i;
    logic                 read_complete_i;
    logic [8:0]           bram_addr_o;
    logic [2:0]           bram_we_o;
    logic [SLOT_BITS-1:0] slot_o;
    logic                 header_we_o;
    logic [15:0]          event_count_o;
    logic                 data_available_o;
    logic                 full_o;
    logic                 busy_o;
    logic                 write_complete_o;
    logic                 drop_o;
    logic                 underflow_o;

    modport master (
        output clk_ce_i, trig_i, read_complete_i,
        input  bram_addr_o, bram_we_o, slot_o, header_we_o, event_count_o,
               data_available_o, full_o, busy_o, write_complete_o, drop_o, underflow_o
    );

    modport slave (
        input  clk_ce_i, trig_i, read_complete_i,
        output bram_addr_o, bram_we_o, slot_o, header_we_o, event_count_o,
               data_available_o, full_o, busy_o, write_complete_o, drop_o, underflow_o
    );
endinterface

// File: rtl/uram_event_write_sm_occupancy.sv
// Slot occupancy counter with registered available/full flags and sticky underflow.
module uram_event_occupancy #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_BITS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic data_available,
    output logic full,
    output logic underflow
);
    localparam int OCC_W = SLOT_BITS + 1;

    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic             inc_ok;
    logic             dec_ok;

    always_comb begin
        inc_ok  = inc && (occ != OCC_W'(NUM_SLOTS));
        dec_ok  = dec && (occ != '0);
        occ_nxt = occ;
        if (inc_ok && !dec_ok)
            occ_nxt = occ + 1'b1;
        else if (dec_ok && !inc_ok)
            occ_nxt = occ - 1'b1;
    end

    // Flags are registered from the next count so they track occ exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ            <= '0;
            data_available <= 1'b0;
            full           <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            occ            <= occ_nxt;
            data_available <= (occ_nxt != '0);
            full           <= (occ_nxt == OCC_W'(NUM_SLOTS));
            if (dec && (occ == '0))
                underflow <= 1'b1;
        end
    end
endmodule

// File: rtl/uram_event_write_sm.sv
// Writes one 1536-word event per accepted trigger across three BRAMs, tracking slot ownership.
module uram_event_write_sm #(
    parameter int NUM_SLOTS = uram_event_pkg::NUM_SLOTS,
    parameter int SLOT_BITS = uram_event_pkg::SLOT_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    uram_event_write_sm_if.slave  bus
);
    import uram_event_pkg::*;

    state_e               state;
    logic [6:0]           uaddr;
    logic [1:0]           laddr;
    logic [2:0]           active_bram;
    logic [SLOT_BITS-1:0] slot;
    logic [15:0]          event_count;
    logic                 full;
    logic                 accept;
    logic                 write_done;
    logic                 last_word;

    assign accept     = !rst_i && bus.clk_ce_i && bus.trig_i && (state == IDLE) && !full;
    assign write_done = !rst_i && bus.clk_ce_i && (state == DONE);
    assign last_word  = (uaddr == 7'(UADDR_LAST)) && (laddr == 2'd3) && active_bram[2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            uaddr       <= '0;
            laddr       <= '0;
            active_bram <= 3'b001;
            slot        <= '0;
            event_count <= '0;
        end else if (bus.clk_ce_i) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= WRITE;
                        event_count <= event_count + 16'd1;
                    end
                end
                WRITE: begin
                    // Address wraps naturally to {0,0} on bram 001 after the last word.
                    laddr <= laddr + 2'd1;
                    if (laddr == 2'd3) begin
                        active_bram <= next_bram(active_bram);
                        if (active_bram[2])
                            uaddr <= uaddr + 7'd1;
                    end
                    if (last_word)
                        state <= DONE;
                end
                DONE: begin
                    slot  <= (slot == SLOT_BITS'(NUM_SLOTS - 1)) ? '0 : slot + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    uram_event_occupancy #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_BITS (SLOT_BITS)
    ) u_occupancy (
        .clk            (clk_i),
        .rst            (rst_i),
        .inc            (write_done),
        .dec            (bus.read_complete_i),
        .data_available (bus.data_available_o),
        .full           (full),
        .underflow      (bus.underflow_o)
    );

    assign bus.full_o           = full;
    assign bus.bram_addr_o      = {uaddr, laddr};
    assign bus.bram_we_o        = (!rst_i && bus.clk_ce_i && (state == WRITE)) ? active_bram : 3'b000;
    assign bus.slot_o           = slot;
    assign bus.header_we_o      = accept;
    assign bus.event_count_o    = event_count;
    assign bus.busy_o           = (state != IDLE);
    assign bus.write_complete_o = write_done;
    assign bus.drop_o           = !rst_i && bus.clk_ce_i && bus.trig_i && ((state != IDLE) || full);
endmodule

// File: tb/tb_uram_event_write_sm.sv
// Directed bench: expected BRAM writes queued per accepted trigger, popped as the DUT writes.
module tb_uram_event_write_sm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   ce_tog = 1'b0;

    int n_cmp  = 0;
    int n_err  = 0;
    int wr_cnt = 0;
    int wc_cnt = 0;
    logic [8:0]  last_addr = '0;
    logic [2:0]  last_we   = '0;
    logic [11:0] sb_q[$];

    initial forever #5 clk = ~clk;

    uram_event_write_sm_if #(.SLOT_BITS(2)) bus ();

    uram_event_write_sm #(
        .NUM_SLOTS (4),
        .SLOT_BITS (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Phase enable: constant 1, or toggling every clock when ce_tog is set.
    initial begin
        bus.clk_ce_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.clk_ce_i = ce_tog ? ~bus.clk_ce_i : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bus.write_complete_o === 1'b1)
            wc_cnt++;
        if (bus.bram_we_o !== 3'b000) begin
            wr_cnt++;
            last_addr = bus.bram_addr_o;
            last_we   = bus.bram_we_o;
            if (sb_q.size() == 0)
                chk("spurious_write", {20'h0, bus.bram_addr_o, bus.bram_we_o}, 32'h0);
            else
                chk("write", {20'h0, bus.bram_addr_o, bus.bram_we_o}, {20'h0, sb_q.pop_front()});
        end
    end

    task automatic pulse_trig(input bit acc);
        logic [11:0] e;
        @(posedge clk); #2;
        for (int k = 0; k < 4 && bus.clk_ce_i !== 1'b1; k++) begin
            @(posedge clk); #2;
        end
        if (acc)
            for (int u = 0; u < 128; u++)
                for (int b = 0; b < 3; b++)
                    for (int l = 0; l < 4; l++) begin
                        e = {7'(u), 2'(l), 3'(1 << b)};
                        sb_q.push_back(e);
                    end
        bus.trig_i = 1'b1;
        @(negedge clk);
        chk("header_we", bus.header_we_o, acc);
        chk("drop", bus.drop_o, !acc);
        @(posedge clk); #2;
        bus.trig_i = 1'b0;
    endtask

    task automatic pulse_read();
        @(posedge clk); #2;
        bus.read_complete_i = 1'b1;
        @(posedge clk); #2;
        bus.read_complete_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || bus.busy_o !== 1'b0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_timeout"}, k < budget, 1);
    endtask

    initial begin
        int base;
        int k;
        int wc0;
        bus.trig_i          = 1'b0;
        bus.read_complete_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", bus.bram_addr_o, 0);
        chk("rst_we", bus.bram_we_o, 0);
        chk("rst_slot", bus.slot_o, 0);
        chk("rst_count", bus.event_count_o, 0);
        chk("rst_avail", bus.data_available_o, 0);
        chk("rst_full", bus.full_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_wc", bus.write_complete_o, 0);
        chk("rst_underflow", bus.underflow_o, 0);
        @(posedge clk); #3;
        rst = 1'b0;

        // Single event with toggling phase enable
        ce_tog = 1'b1;
        pulse_trig(1'b1);
        chk("count_1", bus.event_count_o, 1);
        wait_idle(5000, "ev1");
        chk("ev1_wc", wc_cnt, 1);
        chk("ev1_writes", wr_cnt, 1536);
        chk("ev1_last_addr", last_addr, 9'h1FF);
        chk("ev1_last_we", last_we, 3'b100);
        chk("ev1_avail", bus.data_available_o, 1);
        chk("ev1_slot", bus.slot_o, 1);
        chk("ev1_full", bus.full_o, 0);

        // Read down to empty, then underflow
        pulse_read();
        chk("rd_avail", bus.data_available_o, 0);
        chk("rd_underflow", bus.underflow_o, 0);
        pulse_read();
        chk("uf_set", bus.underflow_o, 1);
        chk("uf_avail", bus.data_available_o, 0);

        // Trigger during WRITE is dropped
        ce_tog = 1'b0;
        pulse_trig(1'b1);
        chk("count_2", bus.event_count_o, 2);
        repeat (50) @(posedge clk);
        pulse_trig(1'b0);
        chk("drop_count", bus.event_count_o, 2);
        chk("drop_busy", bus.busy_o, 1);
        wait_idle(5000, "ev2");
        chk("ev2_wc", wc_cnt, 2);
        chk("ev2_slot", bus.slot_o, 2);
        chk("uf_sticky", bus.underflow_o, 1);

        // Reset clears sticky underflow and all counters
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst2_underflow", bus.underflow_o, 0);
        chk("rst2_slot", bus.slot_o, 0);
        chk("rst2_count", bus.event_count_o, 0);
        chk("rst2_avail", bus.data_available_o, 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;

        // Fill all slots; fifth trigger dropped
        for (int i = 0; i < 4; i++) begin
            pulse_trig(1'b1);
            wait_idle(5000, "fill");
        end
        chk("fill_count", bus.event_count_o, 4);
        chk("fill_full", bus.full_o, 1);
        chk("fill_avail", bus.data_available_o, 1);
        chk("fill_wc", wc_cnt, 6);
        chk("fill_slot", bus.slot_o, 0);
        pulse_trig(1'b0);
        chk("full_drop_count", bus.event_count_o, 4);
        chk("full_drop_busy", bus.busy_o, 0);

        // Read and write-complete in the same cycle
        pulse_read();
        chk("sim_pre_full", bus.full_o, 0);
        pulse_trig(1'b1);
        chk("count_5", bus.event_count_o, 5);
        base = wr_cnt;
        k = 0;
        while (wr_cnt < base + 1536 && k < 4000) begin
            @(posedge clk); #2;
            k++;
        end
        chk("sim_timeout", k < 4000, 1);
        bus.read_complete_i = 1'b1;
        @(negedge clk);
        chk("sim_wc", bus.write_complete_o, 1);
        @(posedge clk); #2;
        bus.read_complete_i = 1'b0;
        chk("sim_full", bus.full_o, 0);
        chk("sim_avail", bus.data_available_o, 1);
        pulse_trig(1'b1);
        wait_idle(5000, "sim_next");
        chk("sim_next_full", bus.full_o, 1);

        // Reset at write 700 abandons the event
        pulse_read();
        pulse_trig(1'b1);
        chk("count_7", bus.event_count_o, 7);
        base = wr_cnt;
        wc0  = wc_cnt;
        k = 0;
        while (wr_cnt < base + 700 && k < 2000) begin
            @(posedge clk); #2;
            k++;
        end
        chk("w700_timeout", k < 2000, 1);
        chk("w700_writes", wr_cnt - base, 700);
        rst = 1'b1;
        #1;
        chk("w700_we", bus.bram_we_o, 0);
        chk("w700_busy", bus.busy_o, 0);
        chk("w700_addr", bus.bram_addr_o, 0);
        chk("w700_count", bus.event_count_o, 0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        chk("w700_no_wc", wc_cnt, wc0);
        #3;
        rst = 1'b0;
        chk("w700_slot", bus.slot_o, 0);
        pulse_trig(1'b1);
        chk("w700_count_1", bus.event_count_o, 1);
        wait_idle(5000, "w700_ev");
        chk("w700_ev_slot", bus.slot_o, 1);
        chk("w700_ev_wc", wc_cnt, wc0 + 1);
        chk("w700_ev_avail", bus.data_available_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uram_event_write_sm.md
URAM_EVENT_WRITE_SM -- requirements
Module: uram_event_write_sm

Interface
REQ-001 SHALL have parameters: NUM_SLOTS, default 4, number of event buffers; SLOT_BITS, default 2, log2(NUM_SLOTS).
REQ-002 SHALL have one clock and an asynchronous, active-high reset (clk_i, rst_i); this is already decided.
REQ-003 SHALL have ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- clk_ce_i  input  1  phase enable; all state advances qualify on it
- trig_i  input  1  event-start flag, sampled when clk_ce_i=1
- read_complete_i  input  1  flag from reader complete_o, frees one slot
- bram_addr_o  output  9  {uaddr[6:0], laddr[1:0]}
- bram_we_o  output  3  one-hot BRAM write enable, all 8 channels in parallel
- slot_o  output  SLOT_BITS  event slot being written
- header_we_o  output  1  one-cycle header write flag
- event_count_o  output  16  accepted-event counter
- data_available_o  output  1  at least one complete event stored
- full_o  output  1  all slots occupied
- busy_o  output  1  WRITE in progress
- write_complete_o  output  1  one-cycle flag, event fully written
- drop_o  output  1  one-cycle flag, trigger discarded
- underflow_o  output  1  sticky, read_complete_i with zero occupancy

Function
REQ-004 SHALL implement states IDLE, WRITE, DONE.
REQ-005 IDLE->WRITE when clk_ce_i && trig_i && !full_o; header_we_o=1 that cycle; event_count_o increments (wraps 0xFFFF->0).
REQ-006 In IDLE, clk_ce_i && trig_i && full_o SHALL pulse drop_o and stay IDLE.
REQ-007 In WRITE/DONE, clk_ce_i && trig_i SHALL pulse drop_o; the event in progress is unaffected.
REQ-008 WRITE: bram_we_o = active_bram when clk_ce_i=1, else 000; first write on the first clk_ce_i cycle after entry, addr 0x000, bram 001.
REQ-009 Each write cycle: laddr increments; at laddr=3, active_bram rotates 001->010->100->001; at bram 100 with laddr=3, uaddr increments.
REQ-010 Write at uaddr=127, laddr=3, bram 100 (1536th) SHALL be the last; WRITE->DONE.
REQ-011 DONE (one clk_ce_i cycle): write_complete_o=1, slot_o increments modulo NUM_SLOTS, occupancy increments; ->IDLE.
REQ-012 Occupancy SHALL be a 0..NUM_SLOTS counter: +1 on write_complete_o, -1 on read_complete_i, unchanged when both occur in the same cycle.
REQ-013 read_complete_i at occupancy 0 SHALL be ignored and set underflow_o (cleared only by reset).
REQ-014 data_available_o = (occupancy != 0); full_o = (occupancy == NUM_SLOTS); both registered from the occupancy counter, updated the cycle after the event.
REQ-015 busy_o=1 in WRITE and DONE.
REQ-016 write_complete_o, header_we_o, drop_o SHALL each be one clk_i cycle wide (coincide with clk_ce_i).
REQ-017 read_complete_i SHALL be honoured regardless of clk_ce_i.

Reset
REQ-018 rst_i SHALL asynchronously force IDLE, addr 0, active_bram 001, slot 0, occupancy 0, event_count 0, underflow 0; all outputs 0 except active_bram-derived internal state.
REQ-019 Reset mid-WRITE SHALL abandon the partial event without write_complete_o; first clk_ce_i after release acts as IDLE.

Structure
REQ-020 Package uram_event_pkg SHALL hold NUM_SLOTS, SLOT_BITS, WORDS_PER_EVENT=1536, and the state enum.
REQ-021 Occupancy counter and flags SHALL be sub-module uram_event_occupancy.

Verification
REQ-022 Single trig_i, clk_ce_i toggling -> exactly 1536 bram_we_o cycles, addr sequence 000..003 per bram, final addr 0x1FF on bram 100, one write_complete_o, data_available_o=1, slot_o=1.
REQ-023 Five back-to-back triggers, no reads -> 4 complete events, full_o=1, fifth trigger drop_o, event_count_o=4.
REQ-024 Full, then read_complete_i and write_complete_o same cycle -> occupancy unchanged, full_o stays consistent.
REQ-025 read_complete_i with occupancy 0 -> no change, underflow_o=1 until rst_i.
REQ-026 rst_i asserted at write 700 -> immediate IDLE, bram_we_o=000, no write_complete_o; next trig_i starts at addr 0, slot 0.
REQ-027 trig_i during WRITE -> drop_o pulse, write sequence uninterrupted, event_count_o unchanged.
